// File: rtl/seq_shift_right_if.sv
// Operand/result bundle for the multi-cycle right shifter.
// The master side issues start with operands; the slave side reports busy/done/result.
interface seq_shift_right_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
);
   logic               start;
   logic [WIDTH-1:0]   data_in;
   logic [SHAMT_W-1:0] shamt;
   logic               arith;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   result;

   modport master (
      output start, data_in, shamt, arith,
      input  busy, done, result
   );

   modport slave (
      input  start, data_in, shamt, arith,
      output busy, done, result
   );
endinterface

// File: rtl/seq_shift_right.sv
// Multi-cycle SRL/SRA: one bit per cycle under a start/busy/done handshake.
// Define SEQ_SHIFT_FAST4_EN to retire 4 bits per cycle while at least 4 remain.
module seq_shift_right #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input logic                      clk,
   input logic                      reset,
   seq_shift_right_if.slave         sh_if
);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic [SHAMT_W-1:0]   count_q, count_d;
   logic                 fill_q, fill_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         result_q <= '0;
         count_q  <= '0;
         fill_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         count_q  <= count_d;
         fill_q   <= fill_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      count_d  = count_q;
      fill_d   = fill_q;

      case (state_q)
         StIdle: begin
            if (sh_if.start) begin
               result_d = sh_if.data_in;
               count_d  = sh_if.shamt;
               // Fill is frozen here so later data_in changes cannot corrupt SRA.
               fill_d   = sh_if.arith & sh_if.data_in[WIDTH-1];
               state_d  = (sh_if.shamt != '0) ? StShift : StDone;
            end
         end

         StShift: begin
`ifdef SEQ_SHIFT_FAST4_EN
            if (count_q >= SHAMT_W'(4)) begin
               result_d = {{4{fill_q}}, result_q[WIDTH-1:4]};
               count_d  = count_q - SHAMT_W'(4);
            end else begin
               result_d = {fill_q, result_q[WIDTH-1:1]};
               count_d  = count_q - SHAMT_W'(1);
            end
            if (count_d == '0) begin
               state_d = StDone;
            end
`else
            result_d = {fill_q, result_q[WIDTH-1:1]};
            count_d  = count_q - SHAMT_W'(1);
            if (count_q == SHAMT_W'(1)) begin
               state_d = StDone;
            end
`endif
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign sh_if.busy   = (state_q != StIdle);
   assign sh_if.done   = (state_q == StDone);
   assign sh_if.result = result_q;

endmodule

// File: tb/tb_seq_shift_right.sv
// Scoreboard bench for seq_shift_right: stimulus pushes expected result and completion edge,
// a monitor pops and compares on every done pulse.
module tb_seq_shift_right;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned SHAMT_W = 5;

   typedef struct {
      logic [31:0] res;
      int          due;
   } exp_t;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   bit   prev_done = 1'b0;
   exp_t sb_q[$];

   seq_shift_right_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) sh ();

   seq_shift_right #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .sh_if (sh.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at edge %0d", nm, act, exp, edge_cnt);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] d, input int s, input bit a);
      if (a) return 32'($signed(d) >>> s);
      return d >> s;
   endfunction

   function automatic int latency(input int s);
`ifdef SEQ_SHIFT_FAST4_EN
      return s / 4 + s % 4;
`else
      return s;
`endif
   endfunction

   // Accept at the next edge; optionally keep start high, or poke start mid-operation.
   task automatic issue(input logic [31:0] d, input int s, input bit a, input bit hold,
                        input int poke);
      exp_t        e;
      int          lat;
      logic [31:0] ref_v;
      ref_v      = model(d, s, a);
      lat        = latency(s);
      sh.start   = 1'b1;
      sh.data_in = d;
      sh.shamt   = 5'(s);
      sh.arith   = a;
      @(posedge clk);
      #1;
      e.res = ref_v;
      e.due = edge_cnt + lat;
      sb_q.push_back(e);
      if (!hold) sh.start = 1'b0;
      for (int i = 1; i <= lat + 1; i++) begin
         @(posedge clk);
         #1;
         if (poke != 0 && i == poke) begin
            sh.start   = 1'b1;
            sh.data_in = 32'hFFFF_FFFF;
            sh.shamt   = 5'd1;
            sh.arith   = 1'b1;
         end else if (poke != 0 && i == poke + 1) begin
            sh.start = 1'b0;
         end
      end
      chk("result_hold", sh.result, ref_v);
   endtask

   // Monitor: every done pulse must match the oldest expectation, in value and timing.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (prev_done) begin
            chk("busy_after_done", {31'b0, sh.busy}, 32'd0);
            chk("done_one_cycle", {31'b0, sh.done}, 32'd0);
         end
         prev_done = sh.done;
         if (sh.done) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done actual=done required=no_done at edge %0d", edge_cnt);
            end else begin
               e = sb_q.pop_front();
               chk("result", sh.result, e.res);
               chk("latency_edge", 32'(edge_cnt), 32'(e.due));
               chk("busy_in_done", {31'b0, sh.busy}, 32'd1);
            end
         end
      end
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;
      int          s;
      bit          a;
      bit          h;

      reset      = 1'b1;
      sh.start   = 1'b0;
      sh.data_in = '0;
      sh.shamt   = '0;
      sh.arith   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_result", sh.result, 32'd0);
      chk("reset_busy", {31'b0, sh.busy}, 32'd0);
      chk("reset_done", {31'b0, sh.done}, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      issue(32'hA5A5_A5A5, 2, 1'b0, 1'b0, 0);
      issue(32'hA5A5_A5A5, 2, 1'b1, 1'b0, 0);
      issue(32'h8000_0000, 31, 1'b1, 1'b0, 0);
      issue(32'h8000_0000, 31, 1'b0, 1'b0, 0);
      issue(32'h0000_0004, 2, 1'b0, 1'b0, 0);
      issue(32'h9696_9694, 2, 1'b0, 1'b0, 0);
      issue(32'h1234_5678, 0, 1'b0, 1'b1, 0);
      issue(32'hCAFE_F00D, 3, 1'b1, 1'b1, 0);
      issue(32'h0F0F_0F0F, 0, 1'b1, 1'b0, 0);
      issue(32'h8765_4321, 10, 1'b0, 1'b0, 3);
      issue(32'hF000_1234, 13, 1'b1, 1'b0, 0);

      // Abort in the 5th SHIFT cycle: nothing should complete.
      sh.start   = 1'b1;
      sh.data_in = 32'hDEAD_BEEF;
      sh.shamt   = 5'd10;
      sh.arith   = 1'b1;
      @(posedge clk);
      #1;
      sh.start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_result", sh.result, 32'd0);
      chk("abort_busy", {31'b0, sh.busy}, 32'd0);
      chk("abort_done", {31'b0, sh.done}, 32'd0);
      reset = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk("abort_idle_busy", {31'b0, sh.busy}, 32'd0);
      issue(32'h8000_00F0, 4, 1'b1, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         d = $urandom;
         s = int'($urandom_range(0, 31));
         a = 1'($urandom_range(0, 1));
         h = ($urandom_range(0, 3) == 0);
         issue(d, s, a, h, 0);
      end
      sh.start = 1'b0;

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_shift_right.md
Name: seq_shift_right

Overview:
- Multi-cycle right shifter: the inverse direction of the datapath's shift-left-by-2 address unit.
- Converts byte quantities back to word quantities and executes SRL/SRA for the multicycle ALU path.
- Shifts 1 bit per cycle under a start/busy/done handshake.
- Sits beside the ALU; the control FSM stalls on busy.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- data_in  input  WIDTH  operand, captured when start is accepted.
- shamt  input  SHAMT_W  shift amount, captured when start is accepted.
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured when start is accepted.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  WIDTH  shift register contents; held after done until the next accepted start.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state = IDLE
  - result = 0, internal count = 0, captured fill bit = 0
  - busy = 0, done = 0
- Reset takes priority over all other inputs. Reset mid-operation aborts the operation, and no done pulse is generated.
- States: IDLE, SHIFT, DONE. busy and done are Moore outputs decoded from state.
- IDLE:
  - On an edge with start=1: result <= data_in, count <= shamt, fill <= arith & data_in[WIDTH-1].
  - Next state is SHIFT if shamt != 0, otherwise DONE.
  - With start=0, state and result hold.
- SHIFT, each edge:
  - result <= {fill, result[WIDTH-1:1]}
  - count <= count - 1
  - If count == 1, the next state is DONE; otherwise stay in SHIFT.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge returns to IDLE unconditionally. start in DONE is ignored.
- start while busy is ignored. It is not queued, and the operands in flight are unaffected by input changes.
- Latency: start accepted at edge N; done is high in the cycle after edge N+shamt.
  - shamt=0: done in the cycle after edge N, result = data_in.
  - shamt=WIDTH-1: done after edge N+31 (WIDTH=32).
  - Total occupancy from acceptance to a new start being accepted: shamt+2 edges.
- Fill bit is fixed at capture, so SRA of a negative value stays all-ones at the top for any shamt. SRL always zero-fills.
- result shows intermediate values during SHIFT. Consumers sample it only when done=1, or in IDLE after done.
- A back-to-back start in the IDLE cycle immediately after DONE is accepted normally.

Optional Feature:
- Macro: SEQ_SHIFT_FAST4_EN.
- When defined: in SHIFT, if count >= 4, shift by 4 per edge (top 4 bits = fill) and count -= 4; otherwise shift by 1.
  - Exit to DONE when the post-update count is 0.
  - Latency: done after floor(shamt/4) + (shamt mod 4) SHIFT edges; shamt=0 still goes straight to DONE.
- When undefined: 1 bit per edge exactly as above, with no 4-bit logic synthesized.
- Ports and handshake are identical in both builds.

Test Plan:
- Logical shift: reset 2 cycles; start, data_in=0xA5A5A5A5, shamt=2, arith=0 -> done high the 3rd cycle after acceptance, result=0x29696969, busy low the following cycle.
- Arithmetic shift: data_in=0xA5A5A5A5, shamt=2, arith=1 -> result=0xE9696969. Then data_in=0x80000000, shamt=31, arith=1 -> result=0xFFFFFFFF after 31 SHIFT cycles; arith=0 -> result=0x00000001.
- Inverse of shift-left-2: data_in=0x00000004, shamt=2, arith=0 -> result=0x00000001. data_in=0x96969694, shamt=2, arith=0 -> result=0x25A5A5A5.
- Zero shift and back-to-back: shamt=0, data_in=0x12345678 -> done in the first cycle after acceptance, result=0x12345678. Then start held high continuously -> second operation accepted in the IDLE cycle after DONE, exactly one done pulse per operation.
- Busy ignore: during a shamt=10 operation, pulse start with data_in=0xFFFFFFFF, shamt=1 -> ignored; result matches the original operation; only one done pulse.
- Reset mid-operation: assert reset at the 5th SHIFT cycle -> next cycle state IDLE, result=0, busy=0, no done pulse. A fresh start afterwards completes normally. With SEQ_SHIFT_FAST4_EN defined, shamt=13 -> done after 4 SHIFT edges (3×4 + 1×1).
